// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : calc_pkg
// Description : Address-width helpers for frame-RAM addressing. Every helper
//               returns at least 1 so a degenerate dimension still yields a
//               legal vector width.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

   // Smallest bit count able to index 'value' distinct items (minimum 1).
   function automatic int clog2_min1(input int value);
      int bits;
      bits = 1;
      while ((1 << bits) < value) bits++;
      return bits;
   endfunction

   function automatic int num_row_address_bits(input int pixel_height);
      return clog2_min1(pixel_height);
   endfunction

   function automatic int num_column_address_bits(input int pixel_width);
      return clog2_min1(pixel_width);
   endfunction

   function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
      return clog2_min1(bytes_per_pixel);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cmd_pkg
// Description : Shared types and constants for the multi-row write command.
//               readrows_state_t       - decoder state encoding
//               CMD_READROWS_MAX_ROWS  - default per-command row limit
//               num_rows_left_bits()   - width of the remaining-row counter
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_pkg;

   typedef enum logic [2:0] {
      S_ROW   = 3'd0,
      S_COUNT = 3'd1,
      S_DATA  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } readrows_state_t;

   localparam int CMD_READROWS_MAX_ROWS = 8;

   // The counter must hold MAX_ROWS itself, not just MAX_ROWS-1.
   function automatic int num_rows_left_bits(input int max_rows);
      return calc_pkg::clog2_min1(max_rows + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/params.sv
`default_nettype none
// ============================================================================
// Package     : params
// Description : Default panel geometry shared by the command decoders.
//               BYTES_PER_PIXEL - colour bytes per pixel
//               PIXEL_HEIGHT    - panel rows
//               PIXEL_WIDTH     - panel columns
// Revision    : 1.0 - initial release
// ============================================================================
package params;
   localparam int BYTES_PER_PIXEL = 2;
   localparam int PIXEL_HEIGHT    = 32;
   localparam int PIXEL_WIDTH     = 64;
endpackage
`default_nettype wire

// File: rtl/readrows_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : readrows_addr_gen
// Description : Column/pixel/row down-counters for the multi-row write
//               command. Pixel counts down first, then column; after
//               (column 0, pixel 0) the row advances with wrap to 0 and the
//               remaining-row count decrements.
// Ports       : clk, reset_n          - clock, synchronous active-low reset
//               load_row, row_in      - capture start row
//               load, count_in        - start scan of count_in rows
//               step                  - advance one payload byte
//               row/column/pixel      - current scan address
//               last_in_row           - current byte is (column 0, pixel 0)
//               last_in_cmd           - current row is the final row
// Revision    : 1.0 - initial release
// ============================================================================
module readrows_addr_gen
   import cmd_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
   parameter int PIXEL_HEIGHT    = params::PIXEL_HEIGHT,
   parameter int PIXEL_WIDTH     = params::PIXEL_WIDTH,
   parameter int MAX_ROWS        = CMD_READROWS_MAX_ROWS,
   localparam int RB  = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
   localparam int CB  = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
   localparam int PB  = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL),
   localparam int RLB = num_rows_left_bits(MAX_ROWS)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           load_row,
   input  logic [RB-1:0]  row_in,
   input  logic           load,
   input  logic [RLB-1:0] count_in,
   input  logic           step,
   output logic [RB-1:0]  row,
   output logic [CB-1:0]  column,
   output logic [PB-1:0]  pixel,
   output logic           last_in_row,
   output logic           last_in_cmd
);

   localparam logic [RB-1:0]  C_ROW_LAST = RB'(PIXEL_HEIGHT - 1);
   localparam logic [CB-1:0]  C_COL_TOP  = CB'(PIXEL_WIDTH - 1);
   localparam logic [PB-1:0]  C_PIX_TOP  = PB'(BYTES_PER_PIXEL - 1);

   logic [RB-1:0]  r_row;
   logic [CB-1:0]  r_column;
   logic [PB-1:0]  r_pixel;
   logic [RLB-1:0] r_rows_left;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_row       <= '0;
         r_column    <= '0;
         r_pixel     <= '0;
         r_rows_left <= '0;
      end else begin
         if (load_row) begin
            r_row <= row_in;
         end
         if (load) begin
            r_column    <= C_COL_TOP;
            r_pixel     <= C_PIX_TOP;
            r_rows_left <= count_in;
         end else if (step) begin
            if (r_pixel != '0) begin
               r_pixel <= r_pixel - PB'(1);
            end else begin
               r_pixel <= C_PIX_TOP;
               if (r_column != '0) begin
                  r_column <= r_column - CB'(1);
               end else begin
                  // Row finished: reload the column and advance with wrap.
                  r_column    <= C_COL_TOP;
                  r_row       <= (r_row == C_ROW_LAST) ? '0 : r_row + RB'(1);
                  r_rows_left <= r_rows_left - RLB'(1);
               end
            end
         end
      end
   end

   assign row         = r_row;
   assign column      = r_column;
   assign pixel       = r_pixel;
   assign last_in_row = (r_column == '0) && (r_pixel == '0);
   assign last_in_cmd = (r_rows_left == RLB'(1));

endmodule
`default_nettype wire

// File: rtl/control_cmd_readrows.sv
`default_nettype none
// ============================================================================
// Module      : control_cmd_readrows
// Description : Multi-row frame-RAM write command decoder. Byte stream is
//               start row, row count, then rows*PIXEL_WIDTH*BYTES_PER_PIXEL
//               payload bytes. Each payload byte is presented on data_out
//               together with the address it was accepted at, and
//               ram_access_start toggles once per byte.
//               Optional feature macro: CMD_READROWS_CHECKSUM_EN - adds a
//               trailing XOR checksum byte over row, count and payload.
// Ports       : clk, reset_n          - clock, synchronous active-low reset
//               data_in, enable       - command byte stream and its valid
//               row/column/pixel      - RAM write address
//               data_out              - registered payload byte
//               ram_write_enable      - high while payload is written
//               ram_access_start      - toggles per payload byte
//               busy, done, error     - command status (error valid w/ done)
// Revision    : 1.0 - initial release
// ============================================================================
module control_cmd_readrows
   import cmd_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
   parameter int PIXEL_HEIGHT    = params::PIXEL_HEIGHT,
   parameter int PIXEL_WIDTH     = params::PIXEL_WIDTH,
   parameter int MAX_ROWS        = CMD_READROWS_MAX_ROWS,
   localparam int RB  = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
   localparam int CB  = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
   localparam int PB  = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL),
   localparam int RLB = num_rows_left_bits(MAX_ROWS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [7:0]    data_in,
   input  logic          enable,
   output logic [RB-1:0] row,
   output logic [CB-1:0] column,
   output logic [PB-1:0] pixel,
   output logic [7:0]    data_out,
   output logic          ram_write_enable,
   output logic          ram_access_start,
   output logic          busy,
   output logic          done,
   output logic          error
);

   readrows_state_t r_state;
   readrows_state_t w_state_next;

   logic           w_load_row;
   logic           w_load;
   logic           w_step;
   logic           w_cmd_end;
   logic           w_last_in_row;
   logic           w_last_in_cmd;
   logic [RB-1:0]  w_row_raw;
   logic [RB-1:0]  w_row_mod;
   logic [RLB-1:0] w_count;
   logic [RB-1:0]  w_gen_row;
   logic [CB-1:0]  w_gen_column;
   logic [PB-1:0]  w_gen_pixel;

   logic [RB-1:0]  r_row;
   logic [CB-1:0]  r_column;
   logic [PB-1:0]  r_pixel;
   logic [7:0]     r_data_out;
   logic           r_ram_write_enable;
   logic           r_ram_access_start;
   logic           r_busy;
   logic           r_done;
   logic           r_error;
`ifdef CMD_READROWS_CHECKSUM_EN
   logic [7:0]     r_csum;
`endif

   // RB bits can hold at most 2*PIXEL_HEIGHT-1, so one conditional subtract
   // completes the modulo.
   assign w_row_raw = RB'(data_in);
   assign w_row_mod = (int'(w_row_raw) >= PIXEL_HEIGHT) ?
                      w_row_raw - RB'(PIXEL_HEIGHT) : w_row_raw;

   assign w_count   = (int'(data_in) > MAX_ROWS) ? RLB'(MAX_ROWS) : RLB'(data_in);
   assign w_cmd_end = w_last_in_row & w_last_in_cmd;

   readrows_addr_gen #(
      .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
      .PIXEL_HEIGHT    (PIXEL_HEIGHT),
      .PIXEL_WIDTH     (PIXEL_WIDTH),
      .MAX_ROWS        (MAX_ROWS)
   ) u_addr_gen (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_row    (w_load_row),
      .row_in      (w_row_mod),
      .load        (w_load),
      .count_in    (w_count),
      .step        (w_step),
      .row         (w_gen_row),
      .column      (w_gen_column),
      .pixel       (w_gen_pixel),
      .last_in_row (w_last_in_row),
      .last_in_cmd (w_last_in_cmd)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_ROW;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load_row   = 1'b0;
      w_load       = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         S_ROW: begin
            if (enable) begin
               w_load_row   = 1'b1;
               w_state_next = S_COUNT;
            end
         end
         S_COUNT: begin
            if (enable) begin
               if (data_in == 8'd0) begin
                  w_state_next = S_DONE;
               end else begin
                  w_load       = 1'b1;
                  w_state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (enable) begin
               w_step = 1'b1;
               if (w_cmd_end) begin
`ifdef CMD_READROWS_CHECKSUM_EN
                  w_state_next = S_CHECK;
`else
                  w_state_next = S_DONE;
`endif
               end
            end
         end
         S_CHECK: begin
            if (enable) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            // Any enable in this cycle is dropped on purpose.
            w_state_next = S_ROW;
         end
         default: begin
            w_state_next = S_ROW;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_row              <= '0;
         r_column           <= '0;
         r_pixel            <= '0;
         r_data_out         <= '0;
         r_ram_write_enable <= 1'b0;
         r_ram_access_start <= 1'b0;
         r_busy             <= 1'b0;
         r_done             <= 1'b0;
         r_error            <= 1'b0;
`ifdef CMD_READROWS_CHECKSUM_EN
         r_csum             <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_ROW: begin
               if (enable) begin
                  r_row  <= w_row_mod;
                  r_busy <= 1'b1;
`ifdef CMD_READROWS_CHECKSUM_EN
                  r_csum <= data_in;
`endif
               end
            end
            S_COUNT: begin
               if (enable) begin
                  if (data_in == 8'd0) begin
                     r_error <= 1'b1;
                     r_done  <= 1'b1;
                  end else begin
                     r_column <= CB'(PIXEL_WIDTH - 1);
                     r_pixel  <= PB'(BYTES_PER_PIXEL - 1);
                  end
`ifdef CMD_READROWS_CHECKSUM_EN
                  r_csum <= r_csum ^ data_in;
`endif
               end
            end
            S_DATA: begin
               if (enable) begin
                  // Address outputs carry the counter value the byte was
                  // accepted at, so they stay aligned with data_out.
                  r_row              <= w_gen_row;
                  r_column           <= w_gen_column;
                  r_pixel            <= w_gen_pixel;
                  r_data_out         <= data_in;
                  r_ram_write_enable <= 1'b1;
                  r_ram_access_start <= ~r_ram_access_start;
`ifdef CMD_READROWS_CHECKSUM_EN
                  r_csum             <= r_csum ^ data_in;
`else
                  if (w_cmd_end) begin
                     r_done <= 1'b1;
                  end
`endif
               end
            end
            S_CHECK: begin
`ifdef CMD_READROWS_CHECKSUM_EN
               if (enable) begin
                  r_error <= (data_in != r_csum);
                  r_done  <= 1'b1;
               end
`endif
            end
            S_DONE: begin
               r_ram_write_enable <= 1'b0;
               r_data_out         <= '0;
               r_busy             <= 1'b0;
               r_error            <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign row              = r_row;
   assign column           = r_column;
   assign pixel            = r_pixel;
   assign data_out         = r_data_out;
   assign ram_write_enable = r_ram_write_enable;
   assign ram_access_start = r_ram_access_start;
   assign busy             = r_busy;
   assign done             = r_done;
   assign error            = r_error;

endmodule
`default_nettype wire

// File: tb/tb_control_cmd_readrows.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_cmd_readrows
// Description : Directed self-checking bench for control_cmd_readrows with
//               PIXEL_WIDTH=4, BYTES_PER_PIXEL=2, PIXEL_HEIGHT=32, MAX_ROWS=8.
//               Honours CMD_READROWS_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_cmd_readrows;

   localparam int W   = 4;
   localparam int BPP = 2;
   localparam int H   = 32;
   localparam int MR  = 8;
   localparam int RB  = 5;
   localparam int CB  = 2;
   localparam int PB  = 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [7:0]    data_in;
   logic          enable;
   logic [RB-1:0] row;
   logic [CB-1:0] column;
   logic [PB-1:0] pixel;
   logic [7:0]    data_out;
   logic          ram_write_enable;
   logic          ram_access_start;
   logic          busy;
   logic          done;
   logic          error;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_strobe = 1'b0;

   always #5 clk = ~clk;

   control_cmd_readrows #(
      .BYTES_PER_PIXEL (BPP),
      .PIXEL_HEIGHT    (H),
      .PIXEL_WIDTH     (W),
      .MAX_ROWS        (MR)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .data_in          (data_in),
      .enable           (enable),
      .row              (row),
      .column           (column),
      .pixel            (pixel),
      .data_out         (data_out),
      .ram_write_enable (ram_write_enable),
      .ram_access_start (ram_access_start),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Present one byte for one clock edge, then sample 1 ns after the edge.
   task automatic put(input logic [7:0] b);
      data_in = b;
      enable  = 1'b1;
      @(posedge clk);
      #1;
      enable  = 1'b0;
   endtask

   task automatic idle();
      enable = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, ".row"},    32'(row), 0);
      check_val({tag, ".column"}, 32'(column), 0);
      check_val({tag, ".pixel"},  32'(pixel), 0);
      check_val({tag, ".data"},   32'(data_out), 0);
      check_val({tag, ".we"},     32'(ram_write_enable), 0);
      check_val({tag, ".strobe"}, 32'(ram_access_start), 0);
      check_val({tag, ".busy"},   32'(busy), 0);
      check_val({tag, ".done"},   32'(done), 0);
      check_val({tag, ".error"},  32'(error), 0);
   endtask

   // Full command: row byte, count byte, payload (base+i), optional trailer.
   task automatic run_cmd(input string tag, input int start, input int cnt,
                          input int base, input bit gaps, input bit flip);
      int   rows;
      int   nbytes;
      int   rr;
      int   kk;
      int   exp_row;
      logic [7:0] b;
      logic [7:0] csum;
      rows   = (cnt > MR) ? MR : cnt;
      nbytes = rows * W * BPP;
      put(8'(start));
      check_val({tag, ".row_byte.row"},  32'(row), 32'((start % 32) % H));
      check_val({tag, ".row_byte.busy"}, 32'(busy), 1);
      csum = 8'(start) ^ 8'(cnt);
      put(8'(cnt));
      if (cnt == 0) begin
         check_val({tag, ".cnt0.done"},   32'(done), 1);
         check_val({tag, ".cnt0.error"},  32'(error), 1);
         check_val({tag, ".cnt0.strobe"}, 32'(ram_access_start), 32'(exp_strobe));
         check_val({tag, ".cnt0.we"},     32'(ram_write_enable), 0);
         // Byte offered during the done cycle must be ignored.
         put(8'h09);
         check_val({tag, ".cnt0.after.done"}, 32'(done), 0);
         check_val({tag, ".cnt0.after.busy"}, 32'(busy), 0);
         check_val({tag, ".cnt0.after.row"},  32'(row), 32'((start % 32) % H));
         return;
      end
      check_val({tag, ".cnt.column"}, 32'(column), W - 1);
      check_val({tag, ".cnt.pixel"},  32'(pixel), BPP - 1);
      check_val({tag, ".cnt.done"},   32'(done), 0);
      for (int i = 0; i < nbytes; i++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            idle();
            check_val({tag, ".gap.strobe"}, 32'(ram_access_start), 32'(exp_strobe));
            check_val({tag, ".gap.done"},   32'(done), 0);
         end
         b = 8'(base + i);
         csum = csum ^ b;
         rr = i / (W * BPP);
         kk = i % (W * BPP);
         exp_row = (((start % 32) % H) + rr) % H;
         put(b);
         exp_strobe = ~exp_strobe;
         check_val({tag, ".data"},   32'(data_out), 32'(b));
         check_val({tag, ".column"}, 32'(column), 32'(W - 1 - kk / BPP));
         check_val({tag, ".pixel"},  32'(pixel), 32'(BPP - 1 - kk % BPP));
         check_val({tag, ".row"},    32'(row), 32'(exp_row));
         check_val({tag, ".we"},     32'(ram_write_enable), 1);
         check_val({tag, ".strobe"}, 32'(ram_access_start), 32'(exp_strobe));
`ifdef CMD_READROWS_CHECKSUM_EN
         check_val({tag, ".done_early"}, 32'(done), 0);
`else
         if (i < nbytes - 1) begin
            check_val({tag, ".done_early"}, 32'(done), 0);
         end else begin
            check_val({tag, ".end.done"},  32'(done), 1);
            check_val({tag, ".end.error"}, 32'(error), 0);
         end
`endif
      end
`ifdef CMD_READROWS_CHECKSUM_EN
      put(flip ? ~csum : csum);
      check_val({tag, ".chk.done"},   32'(done), 1);
      check_val({tag, ".chk.error"},  32'(error), 32'(flip));
      check_val({tag, ".chk.strobe"}, 32'(ram_access_start), 32'(exp_strobe));
`else
      check_val({tag, ".flip_unused"}, 32'(flip), 32'(flip ? 1 : 0));
`endif
      idle();
      check_val({tag, ".post.done"}, 32'(done), 0);
      check_val({tag, ".post.busy"}, 32'(busy), 0);
      check_val({tag, ".post.we"},   32'(ram_write_enable), 0);
      check_val({tag, ".post.data"}, 32'(data_out), 0);
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      data_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      idle();
      check_val("idle.busy", 32'(busy), 0);

      run_cmd("r5c1",   5,  1, 8'h10, 1'b0, 1'b0);
      run_cmd("r31c2",  31, 2, 8'h40, 1'b0, 1'b0);
      run_cmd("cnt0",   12, 0, 8'h00, 1'b0, 1'b0);
      run_cmd("cnt20",  2,  20, 8'h80, 1'b0, 1'b0);
      run_cmd("gaps",   3,  1, 8'hA0, 1'b1, 1'b0);

      // Abort mid-command after payload byte 3.
      put(8'd7);
      put(8'd1);
      for (int i = 0; i < 4; i++) begin
         put(8'(8'hC0 + i));
         exp_strobe = ~exp_strobe;
      end
      check_val("abort.strobe_before", 32'(ram_access_start), 32'(exp_strobe));
      reset_n = 1'b0;
      idle();
      exp_strobe = 1'b0;
      check_all_zero("abort");
      reset_n = 1'b1;
      idle();
      check_val("abort.nodone", 32'(done), 0);
      run_cmd("fresh",  9, 1, 8'h20, 1'b0, 1'b0);

`ifdef CMD_READROWS_CHECKSUM_EN
      run_cmd("csum_ok",  6, 1, 8'h33, 1'b0, 1'b0);
      run_cmd("csum_bad", 6, 1, 8'h33, 1'b0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
